dsp_mac_sequencer: RTL and testbench

Job-level controller that sequences one DSP48A1 slice as a multiply-accumulate engine. It accepts a command giving a job length and accumulate direction, then streams operand pairs into the slice. It drives the slice's OPMODE so the first product starts a fresh sum, later products accumulate, and input bubbles hold the sum. After the pipeline drains it captures the 48-bit P result and returns it on a valid/ready handshake. It sits between a job-issuing engine and a DSP48A1 built with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT" and CARRYINSEL="OPMODE5".

---
 rtl/dsp_mac_sequencer_if.sv | 28 ++
 rtl/dsp_mac_sequencer.sv | 129 ++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_if.sv
// Job-side bus of the MAC sequencer: command, operand stream and result handshakes.
interface dsp_mac_sequencer_if #(
  parameter int unsigned LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_sub;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;

  // Job-issuing engine side.
  modport master (
    output cmd_valid, cmd_len, cmd_sub, in_valid, in_a, in_b, res_ready,
    input  cmd_ready, in_ready, res_valid, res_data
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_len, cmd_sub, in_valid, in_a, in_b, res_ready,
    output cmd_ready, in_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1 slice as a multiply-accumulate engine for one job at a time.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned OPM_DLY  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_mac_sequencer_if.slave   job,
  output logic                 busy,
  output logic [17:0]          dsp_a,
  output logic [17:0]          dsp_b,
  output logic [7:0]           dsp_opmode,
  output logic                 dsp_ce,
  output logic                 dsp_rst,
  input  logic [47:0]          dsp_p
);

  localparam int unsigned DRN_W    = $clog2(PIPE_LAT + 1) + 1;
  localparam logic [7:0]  OPM_HOLD = 8'h08;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             sub_q;
  logic             first_q;
  logic [DRN_W-1:0] drn_q;
  logic [7:0]       opm_pipe [OPM_DLY+1];

  logic             cmd_hs_c;
  logic             in_hs_c;
  logic             res_hs_c;
  logic             drn_end_c;
  logic [7:0]       opm_c;

  assign dsp_rst    = rst;
  assign dsp_opmode = opm_pipe[OPM_DLY];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, handshake strobes and the opmode for the slot issued this cycle.
  always_comb begin
    state_n   = state;
    cmd_hs_c  = 1'b0;
    in_hs_c   = 1'b0;
    res_hs_c  = 1'b0;
    drn_end_c = 1'b0;
    opm_c     = OPM_HOLD;
    case (state)
      IDLE: begin
        cmd_hs_c = job.cmd_valid;
        if (job.cmd_valid) state_n = (job.cmd_len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_hs_c = job.in_valid;
        if (job.in_valid) begin
          opm_c = {sub_q, 3'b000, (first_q ? 4'b0001 : 4'b1001)};
          if (LEN_W'(cnt_q + LEN_W'(1)) == len_q) state_n = DRAIN;
        end
      end
      DRAIN: begin
        drn_end_c = (drn_q == DRN_W'(PIPE_LAT));
        if (drn_end_c) state_n = DONE;
      end
      DONE: begin
        res_hs_c = job.res_valid && job.res_ready;
        if (res_hs_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Job registers, operand/opmode issue and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      job.cmd_ready <= 1'b1;
      job.in_ready  <= 1'b0;
      job.res_valid <= 1'b0;
      job.res_data  <= '0;
      busy          <= 1'b0;
      dsp_a         <= '0;
      dsp_b         <= '0;
      dsp_ce        <= 1'b1;
      len_q         <= '0;
      cnt_q         <= '0;
      sub_q         <= 1'b0;
      first_q       <= 1'b0;
      drn_q         <= '0;
      for (int i = 0; i <= int'(OPM_DLY); i++) opm_pipe[i] <= OPM_HOLD;
    end else begin
      job.cmd_ready <= (state_n == IDLE);
      job.in_ready  <= (state_n == RUN);
      busy          <= (state_n != IDLE);
      dsp_ce        <= 1'b1;
      if (cmd_hs_c) begin
        len_q        <= job.cmd_len;
        sub_q        <= job.cmd_sub;
        cnt_q        <= '0;
        first_q      <= 1'b1;
        job.res_data <= '0;
      end
      if (in_hs_c) begin
        dsp_a   <= job.in_a;
        dsp_b   <= job.in_b;
        cnt_q   <= LEN_W'(cnt_q + LEN_W'(1));
        first_q <= 1'b0;
        drn_q   <= '0;
      end
      if (state == DRAIN) drn_q <= DRN_W'(drn_q + DRN_W'(1));
      if (drn_end_c) begin
        job.res_data  <= dsp_p;
        job.res_valid <= 1'b1;
      end
      // Zero-length jobs raise valid on the first DONE edge.
      if (state == DONE && !job.res_valid) job.res_valid <= 1'b1;
      if (res_hs_c) job.res_valid <= 1'b0;
      opm_pipe[0] <= opm_c;
      for (int i = 1; i <= int'(OPM_DLY); i++) opm_pipe[i] <= opm_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model.
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst;
  logic [47:0] dsp_p;

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] ja [4];
  logic [17:0] jb [4];
  logic [7:0]  olog [$];
  bit          hlog [$];
  logic [7:0]  exp_q [$];
  int          ir_low;

  dsp_mac_sequencer_if #(.LEN_W(16)) job ();

  dsp_mac_sequencer #(.LEN_W(16), .PIPE_LAT(3), .OPM_DLY(1)) dut (
    .clk(clk), .rst(rst), .job(job), .busy(busy),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  always #5 clk = ~clk;

  // DSP48A1 model: A1/B1 reg, M reg, OPMODE reg, P reg; X in {0,M}, Z in {0,P}.
  logic [17:0]        a1, b1;
  logic [47:0]        m_r, p_r, x_c, z_c;
  logic [7:0]         opr;
  logic signed [35:0] prod;
  always_comb begin
    prod = $signed(a1) * $signed(b1);
    x_c  = (opr[1:0] == 2'b01) ? m_r : 48'd0;
    z_c  = (opr[3:2] == 2'b10) ? p_r : 48'd0;
  end
  always_ff @(posedge clk) begin
    if (dsp_rst) begin
      a1 <= '0; b1 <= '0; m_r <= '0; p_r <= '0; opr <= '0;
    end else if (dsp_ce) begin
      a1  <= dsp_a;
      b1  <= dsp_b;
      m_r <= {{12{prod[35]}}, prod};
      opr <= dsp_opmode;
      p_r <= opr[7] ? (z_c - x_c) : (z_c + x_c);
    end
  end
  assign dsp_p = p_r;

  // Issue a command and feed operands (stop early after stop_at pairs); inputs change at negedges.
  task automatic do_job(input logic sub, input int len, input int gap, input int stop_at,
                        output logic [47:0] res, output int lat);
    int i, g, guard;
    bit hs;
    olog.delete(); hlog.delete();
    ir_low = 0; lat = 0; res = '0; i = 0; g = 0; guard = 0;
    job.cmd_valid = 1'b1; job.cmd_len = 16'(len); job.cmd_sub = sub;
    @(negedge clk);
    job.cmd_valid = 1'b0;
    while (i < len && i < stop_at && guard < 200) begin
      job.in_valid = (g == 0);
      job.in_a = ja[i]; job.in_b = jb[i];
      if (!job.in_ready) ir_low++;
      hs = job.in_valid && job.in_ready;
      @(negedge clk);
      olog.push_back(dsp_opmode); hlog.push_back(hs);
      if (hs) begin i++; g = gap; end
      else if (g > 0) g--;
      guard++;
    end
    job.in_valid = 1'b0;
    if (guard >= 200) begin
      n_vec++; n_err++;
      $display("FAIL feed_timeout: %0d of %0d operands accepted in 200 cycles", i, len);
    end
    if (i >= len) begin
      while (!job.res_valid && lat < 20) begin
        @(negedge clk);
        olog.push_back(dsp_opmode); hlog.push_back(1'b0);
        lat++;
      end
      res = job.res_data;
    end
  endtask

  // Expected opmode log: each accepted operand's opmode shows one sample after its handshake.
  task automatic build_exp(input logic sub);
    bit first;
    first = 1'b1;
    exp_q.delete();
    for (int j = 0; j < olog.size(); j++) exp_q.push_back(8'h08);
    for (int j = 0; j + 1 < olog.size(); j++)
      if (hlog[j]) begin
        exp_q[j+1] = {sub, 3'b000, (first ? 4'h1 : 4'h9)};
        first = 1'b0;
      end
  endtask

  task automatic release_res();
    job.res_ready = 1'b1;
    @(negedge clk);
    job.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (job.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b want 1", job.cmd_ready); end
    n_vec++; if (job.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", job.in_ready); end
    n_vec++; if (job.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", job.res_valid); end
    n_vec++; if (job.res_data !== 48'd0) begin n_err++; $display("FAIL rst_res_data got %h want 0", job.res_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if ({dsp_a, dsp_b} !== 36'd0) begin n_err++; $display("FAIL rst_dsp_ab got %h want 0", {dsp_a, dsp_b}); end
    n_vec++; if (dsp_opmode !== 8'h08) begin n_err++; $display("FAIL rst_opmode got %h want 08", dsp_opmode); end
    n_vec++; if (dsp_ce !== 1'b1) begin n_err++; $display("FAIL rst_dsp_ce got %b want 1", dsp_ce); end
    n_vec++; if (dsp_rst !== 1'b1) begin n_err++; $display("FAIL rst_dsp_rst got %b want 1", dsp_rst); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (dsp_rst !== 1'b0) begin n_err++; $display("FAIL dsp_rst_release got %b want 0", dsp_rst); end
  endtask

  task automatic test_add();
    logic [47:0] r; int lat;
    ja = '{18'd1, 18'd3, 18'd5, 18'd7}; jb = '{18'd2, 18'd4, 18'd6, 18'd8};
    do_job(1'b0, 4, 0, 4, r, lat);
    n_vec++; if (r !== 48'd100) begin n_err++; $display("FAIL add_result got %0d want 100", r); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL add_latency got %0d want 4", lat); end
    n_vec++; if (job.in_ready !== 1'b0) begin n_err++; $display("FAIL add_in_ready_done got %b want 0", job.in_ready); end
    build_exp(1'b0);
    for (int j = 0; j < olog.size(); j++) begin
      n_vec++; if (olog[j] !== exp_q[j]) begin n_err++; $display("FAIL add_opmode[%0d] got %h want %h", j, olog[j], exp_q[j]); end
    end
    release_res();
  endtask

  task automatic test_sub();
    logic [47:0] r; int lat;
    do_job(1'b1, 4, 0, 4, r, lat);
    n_vec++; if (r !== 48'hFFFF_FFFF_FF9C) begin n_err++; $display("FAIL sub_result got %h want ffffffffff9c", r); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL sub_latency got %0d want 4", lat); end
    build_exp(1'b1);
    for (int j = 0; j < olog.size(); j++) begin
      n_vec++; if (olog[j] !== exp_q[j]) begin n_err++; $display("FAIL sub_opmode[%0d] got %h want %h", j, olog[j], exp_q[j]); end
    end
    release_res();
  endtask

  task automatic test_bubbles();
    logic [47:0] r; int lat;
    do_job(1'b0, 4, 2, 4, r, lat);
    n_vec++; if (r !== 48'd100) begin n_err++; $display("FAIL bub_result got %0d want 100", r); end
    n_vec++; if (ir_low !== 0) begin n_err++; $display("FAIL bub_in_ready_low got %0d cycles want 0", ir_low); end
    n_vec++; if (olog.size() !== 14) begin n_err++; $display("FAIL bub_log_len got %0d want 14", olog.size()); end
    build_exp(1'b0);
    for (int j = 0; j < olog.size(); j++) begin
      n_vec++; if (olog[j] !== exp_q[j]) begin n_err++; $display("FAIL bub_opmode[%0d] got %h want %h", j, olog[j], exp_q[j]); end
    end
    release_res();
  endtask

  task automatic test_zero_len();
    logic [47:0] r; int lat;
    do_job(1'b0, 0, 0, 4, r, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL zero_latency got %0d want 1", lat); end
    n_vec++; if (r !== 48'd0) begin n_err++; $display("FAIL zero_result got %h want 0", r); end
    n_vec++; if (dsp_opmode !== 8'h08) begin n_err++; $display("FAIL zero_opmode got %h want 08", dsp_opmode); end
    release_res();
  endtask

  task automatic test_back_to_back();
    logic [47:0] r; int lat;
    ja = '{18'd1, 18'd3, 18'd5, 18'd7}; jb = '{18'd2, 18'd4, 18'd6, 18'd8};
    do_job(1'b0, 4, 0, 4, r, lat);
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (job.res_valid !== 1'b1 || job.res_data !== 48'd100 || job.cmd_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL hold[%0d] got valid=%b data=%0d cmd_ready=%b busy=%b want 1/100/0/1",
                 c, job.res_valid, job.res_data, job.cmd_ready, busy);
      end
      @(negedge clk);
    end
    job.res_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (job.res_valid !== 1'b0 || job.cmd_ready !== 1'b1) begin n_err++; $display("FAIL hold_release got valid=%b cmd_ready=%b want 0/1", job.res_valid, job.cmd_ready); end
    ja[0] = 18'd3; jb[0] = 18'd5;
    do_job(1'b0, 1, 0, 4, r, lat);
    n_vec++; if (r !== 48'd15) begin n_err++; $display("FAIL b2b_result got %0d want 15", r); end
    n_vec++; if (olog[1] !== 8'h01) begin n_err++; $display("FAIL b2b_first_opmode got %h want 01", olog[1]); end
    @(negedge clk);
    n_vec++; if (job.res_valid !== 1'b0 || job.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_consume got valid=%b cmd_ready=%b want 0/1", job.res_valid, job.cmd_ready); end
    job.res_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [47:0] r; int lat;
    ja = '{18'd1, 18'd3, 18'd5, 18'd7}; jb = '{18'd2, 18'd4, 18'd6, 18'd8};
    do_job(1'b0, 4, 0, 2, r, lat);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (job.cmd_ready !== 1'b1 || job.in_ready !== 1'b0 || job.res_valid !== 1'b0 || job.res_data !== 48'd0 ||
        busy !== 1'b0 || dsp_a !== 18'd0 || dsp_b !== 18'd0 || dsp_opmode !== 8'h08 || dsp_ce !== 1'b1 || dsp_rst !== 1'b1) begin
      n_err++;
      $display("FAIL abort_reset got cr=%b ir=%b rv=%b rd=%h busy=%b a=%h b=%h opm=%h ce=%b drst=%b",
               job.cmd_ready, job.in_ready, job.res_valid, job.res_data, busy, dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (job.res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_no_result got valid=%b busy=%b want 0/0", job.res_valid, busy); end
    ja[0] = 18'd2; jb[0] = 18'd2;
    do_job(1'b0, 1, 0, 4, r, lat);
    n_vec++; if (r !== 48'd4) begin n_err++; $display("FAIL abort_next_result got %0d want 4", r); end
    release_res();
  endtask

  initial begin
    rst = 1'b1;
    job.cmd_valid = 1'b0; job.cmd_len = '0; job.cmd_sub = 1'b0;
    job.in_valid = 1'b0; job.in_a = '0; job.in_b = '0; job.res_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_bubbles();
    test_zero_len();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
